arena_map: RTL and testbench

- Tile-map store for the 16x16 arena grid; 64-pixel cells, 3-bit element code per cell.
- Sits directly upstream of the arena renderer. The renderer drives the cell address ({row[3:0], col[3:0]}) from the current pixel position and receives the element code, which drives its sprite-ROM select.
- Game logic submits cell updates through a valid/ready port. Updates are queued and committed only during vertical blanking, so a frame never shows a half-updated map.
- Builds the default arena layout on reset and on a new-game clear request.

---
 rtl/arena_map_if.sv | 20 ++
 rtl/arena_map.sv | 137 +++++++++++++
 tb/tb_arena_map.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/arena_map_if.sv
// Renderer read port and game-logic update port of the arena tile map.
// master = renderer/game logic side, slave = arena_map.
interface arena_map_if;
   logic       i_wr_valid;
   logic       o_wr_ready;
   logic [7:0] i_wr_addr;
   logic [2:0] i_wr_data;
   logic [7:0] i_rd_addr;
   logic [2:0] o_rd_data;

   modport master (
      output i_wr_valid, i_wr_addr, i_wr_data, i_rd_addr,
      input  o_wr_ready, o_rd_data
   );

   modport slave (
      input  i_wr_valid, i_wr_addr, i_wr_data, i_rd_addr,
      output o_wr_ready, o_rd_data
   );
endinterface

// File: rtl/arena_map.sv
// 16x16 arena tile map: 1-cycle registered read, updates queued and committed in vblank.
// Update port back-pressures when the queue is full or while the default layout is being rebuilt.
module arena_map #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [2:0] WALL_CODE  = 3'd1,
   parameter logic [2:0] EMPTY_CODE = 3'd0
) (
   input  logic        i_pclk,
   input  logic        i_rst,
   input  logic        i_vblnk,
   input  logic        i_clear,
   output logic        o_init_done,
   arena_map_if.slave  bus
);
   localparam int            PW       = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);

   typedef enum logic {INIT, RUN} state_t;

   state_t          state_q, state_d;
   logic [7:0]      sweep_q, sweep_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q, count_d;
   logic [2:0]      rd_data_q, rd_data_d;

   logic [2:0]      mem_q       [256];
   logic [7:0]      fifo_addr_q [FIFO_DEPTH];
   logic [2:0]      fifo_data_q [FIFO_DEPTH];

   logic            full, wr_ready, push, pop;
   logic            mem_we;
   logic [7:0]      mem_waddr;
   logic [2:0]      mem_wdata;
   logic [3:0]      sw_row, sw_col;
   logic            is_wall;

   assign sw_row  = sweep_q[7:4];
   assign sw_col  = sweep_q[3:0];
   // Border ring plus a pillar on every even row/even column crossing.
   assign is_wall = (sw_row == 4'd0) || (sw_row == 4'd15) ||
                    (sw_col == 4'd0) || (sw_col == 4'd15) ||
                    (!sw_row[0] && !sw_col[0]);

   assign full           = (count_q == FULL_CNT);
   assign wr_ready       = (state_q == RUN) && !full;
   assign bus.o_wr_ready = wr_ready;
   assign bus.o_rd_data  = rd_data_q;
   assign o_init_done    = (state_q == RUN);

   always_comb begin
      state_d   = state_q;
      sweep_d   = sweep_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      push      = 1'b0;
      pop       = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = sweep_q;
      mem_wdata = EMPTY_CODE;
      rd_data_d = mem_q[bus.i_rd_addr];

      case (state_q)
         INIT: begin
            rd_data_d = 3'd0;
            mem_we    = 1'b1;
            mem_waddr = sweep_q;
            mem_wdata = is_wall ? WALL_CODE : EMPTY_CODE;
            sweep_d   = sweep_q + 8'd1;
            if (sweep_q == 8'hFF) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (i_clear) begin
               // Pending updates belong to the old game and are dropped.
               state_d  = INIT;
               sweep_d  = 8'd0;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               count_d  = '0;
            end else begin
               push = bus.i_wr_valid && wr_ready;
               pop  = i_vblnk && (count_q != '0);
               if (pop) begin
                  mem_we    = 1'b1;
                  mem_waddr = fifo_addr_q[rd_ptr_q];
                  mem_wdata = fifo_data_q[rd_ptr_q];
                  rd_ptr_d  = rd_ptr_q + PW'(1);
               end
               if (push) begin
                  wr_ptr_d = wr_ptr_q + PW'(1);
               end
               case ({push, pop})
                  2'b10:   count_d = count_q + (PW+1)'(1);
                  2'b01:   count_d = count_q - (PW+1)'(1);
                  default: count_d = count_q;
               endcase
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge i_pclk) begin
      if (!i_rst) begin
         state_q   <= INIT;
         sweep_q   <= 8'd0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         sweep_q   <= sweep_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Read-first: rd_data_d samples mem_q before this edge's write lands.
   always_ff @(posedge i_pclk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge i_pclk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= bus.i_wr_addr;
         fifo_data_q[wr_ptr_q] <= bus.i_wr_data;
      end
   end
endmodule

// File: tb/tb_arena_map.sv
// Directed bench for arena_map: layout sweep, queued vblank commits, clear and reset restart.
module tb_arena_map;
   logic clk = 1'b0;
   logic rst_n, vblnk, clear;
   logic init_done;
   int   tests = 0;
   int   fails = 0;
   logic [2:0] exp_q [$];

   arena_map_if bus();

   arena_map #(.FIFO_DEPTH(4), .WALL_CODE(3'd1), .EMPTY_CODE(3'd0)) dut (
      .i_pclk      (clk),
      .i_rst       (rst_n),
      .i_vblnk     (vblnk),
      .i_clear     (clear),
      .o_init_done (init_done),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [2:0] dflt(input logic [7:0] a);
      logic [3:0] r;
      logic [3:0] c;
      r = a[7:4];
      c = a[3:0];
      return (r == 4'd0 || r == 4'd15 || c == 4'd0 || c == 4'd15 || (!r[0] && !c[0])) ? 3'd1 : 3'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Drive a read address, queue its expected code, pop and compare one cycle later.
   task automatic rd(input string tag, input logic [7:0] a, input logic [2:0] e);
      logic [2:0] want;
      bus.i_rd_addr = a;
      exp_q.push_back(e);
      tick();
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s: observed=%0h expected=<scoreboard empty>", tag, bus.o_rd_data);
      end else begin
         want = exp_q.pop_front();
         chk(tag, 32'(bus.o_rd_data), 32'(want));
      end
   endtask

   task automatic wr(input string tag, input logic [7:0] a, input logic [2:0] d);
      int n;
      n = 0;
      bus.i_wr_valid = 1'b1;
      bus.i_wr_addr  = a;
      bus.i_wr_data  = d;
      while (!bus.o_wr_ready && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.o_wr_ready), 32'd1);
      tick();
      bus.i_wr_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      vblnk = 1'b0;
      clear = 1'b0;
      bus.i_wr_valid = 1'b0;
      bus.i_wr_addr  = 8'h00;
      bus.i_wr_data  = 3'd0;
      bus.i_rd_addr  = 8'h00;

      tick();
      tick();
      chk("rst_rd_data", 32'(bus.o_rd_data), 32'd0);
      chk("rst_wr_ready", 32'(bus.o_wr_ready), 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);

      // Sweep from reset release: done rises on the 256th edge.
      rst_n = 1'b1;
      for (int c = 1; c <= 256; c++) begin
         tick();
         if (c == 1 || c == 255) chk("init_low", 32'(init_done), 32'd0);
      end
      chk("init_high", 32'(init_done), 32'd1);
      chk("ready_in_run", 32'(bus.o_wr_ready), 32'd1);

      rd("lay_00", 8'h00, 3'd1);
      rd("lay_0F", 8'h0F, 3'd1);
      rd("lay_11", 8'h11, 3'd0);
      rd("lay_22", 8'h22, 3'd1);
      rd("lay_23", 8'h23, 3'd0);
      rd("lay_7A", 8'h7A, 3'd0);
      rd("lay_F7", 8'hF7, 3'd1);
      rd("lay_8E", 8'h8E, 3'd1);

      // Queued update held until vblank; same-cycle read returns the old value.
      wr("acc_11", 8'h11, 3'd2);
      for (int i = 0; i < 100; i++) rd("hold_11", 8'h11, 3'd0);
      vblnk = 1'b1;
      rd("rdfirst_11", 8'h11, 3'd0);
      vblnk = 1'b0;
      rd("commit_11", 8'h11, 3'd2);

      // Fill the queue, then drain it while a fifth update waits.
      wr("acc_33", 8'h33, 3'd2);
      wr("acc_34", 8'h34, 3'd3);
      wr("acc_35", 8'h35, 3'd4);
      wr("acc_36", 8'h36, 3'd5);
      chk("full_ready_low", 32'(bus.o_wr_ready), 32'd0);
      bus.i_wr_valid = 1'b1;
      bus.i_wr_addr  = 8'h37;
      bus.i_wr_data  = 3'd6;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("full_hold", 32'(bus.o_wr_ready), 32'd0);
      end
      vblnk = 1'b1;
      tick();
      chk("ready_after_pop", 32'(bus.o_wr_ready), 32'd1);
      tick();
      bus.i_wr_valid = 1'b0;
      tick();
      tick();
      vblnk = 1'b0;
      rd("drain_33", 8'h33, 3'd2);
      rd("drain_34", 8'h34, 3'd3);
      rd("drain_35", 8'h35, 3'd4);
      rd("drain_36", 8'h36, 3'd5);
      rd("wait_37", 8'h37, 3'd0);
      chk("ready_restored", 32'(bus.o_wr_ready), 32'd1);
      vblnk = 1'b1;
      tick();
      vblnk = 1'b0;
      rd("commit_37", 8'h37, 3'd6);

      // Later update to the same cell wins.
      wr("acc_44a", 8'h44, 3'd2);
      wr("acc_44b", 8'h44, 3'd4);
      vblnk = 1'b1;
      tick();
      tick();
      vblnk = 1'b0;
      rd("order_44", 8'h44, 3'd4);

      // Clear discards queued updates and rebuilds the layout; clear during INIT is ignored.
      wr("acc_55", 8'h55, 3'd7);
      wr("acc_57", 8'h57, 3'd6);
      clear = 1'b1;
      bus.i_rd_addr = 8'h00;
      tick();
      clear = 1'b0;
      chk("clr_done_low", 32'(init_done), 32'd0);
      chk("clr_ready_low", 32'(bus.o_wr_ready), 32'd0);
      vblnk = 1'b1;
      for (int c = 1; c <= 256; c++) begin
         tick();
         if (c == 1)   chk("init_rd_forced0", 32'(bus.o_rd_data), 32'd0);
         if (c == 49)  clear = 1'b1;
         if (c == 50)  clear = 1'b0;
         if (c == 255) chk("clr_init_low", 32'(init_done), 32'd0);
      end
      chk("clr_init_high", 32'(init_done), 32'd1);
      for (int a = 0; a < 256; a++) rd("map_after_clr", 8'(a), dflt(8'(a)));
      vblnk = 1'b0;

      // Reset at sweep address 100 restarts the sweep from zero.
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int c = 1; c <= 100; c++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_done", 32'(init_done), 32'd0);
      chk("midrst_ready", 32'(bus.o_wr_ready), 32'd0);
      chk("midrst_rd", 32'(bus.o_rd_data), 32'd0);
      for (int c = 1; c <= 256; c++) begin
         tick();
         if (c == 255) chk("rst_sweep_low", 32'(init_done), 32'd0);
      end
      chk("rst_sweep_high", 32'(init_done), 32'd1);
      rd("post_rst_8E", 8'h8E, 3'd1);
      rd("post_rst_11", 8'h11, 3'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
